seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 191 +++++++++++++++++++
 tb/tb_seq_alu.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with a valid/ready request port and a valid/ready
// result port. Single-cycle ops return a result one cycle after acceptance;
// DIV/REM with a non-zero divisor run a restoring divider for WIDTH cycles.
// Optional feature macro: SEQ_ALU_MUL_EN enables the MUL opcode (low WIDTH
// bits of a*b); without it MUL is treated as an unsupported opcode.
//
// Handshake: a request is accepted when in_valid & in_ready on a rising edge;
// a result is consumed when out_valid & out_ready on a rising edge. out_valid
// and the result/flags stay stable until consumed. in_valid is never required
// to wait for in_ready, and in_ready does not depend on in_valid.
module seq_alu #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow,
    output logic             err,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int M  = WIDTH - 1;

    localparam logic [4:0] OP_ADD  = 5'b00000, OP_SUB  = 5'b00001, OP_MUL  = 5'b00010;
    localparam logic [4:0] OP_DIV  = 5'b00011, OP_REM  = 5'b00100, OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110, OP_XOR  = 5'b00111, OP_NAND = 5'b01000;
    localparam logic [4:0] OP_NOR  = 5'b01001, OP_XNOR = 5'b01010, OP_NOT  = 5'b01011;
    localparam logic [4:0] OP_NEG  = 5'b01100, OP_SLL  = 5'b01101, OP_SRL  = 5'b01110;
    localparam logic [4:0] OP_SRA  = 5'b01111, OP_SLT  = 5'b10000, OP_SLTU = 5'b10001;
    localparam logic [4:0] OP_INC  = 5'b10010, OP_DEC  = 5'b10011, OP_ROL  = 5'b10100;
    localparam logic [4:0] OP_ROR  = 5'b10101, OP_PSA  = 5'b10110, OP_PSB  = 5'b10111;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_HOLD = 2'd2} state_t;

    state_t             r_state, w_next;
    logic [WIDTH-1:0]   r_result, r_quo, r_rem, r_div;
    logic               r_zero, r_carry, r_ovf, r_err, r_is_rem;
    logic [CW-1:0]      r_cnt;

    logic               w_accept, w_div_start, w_div_last;
    logic [WIDTH-1:0]   w_res;
    logic               w_c, w_v, w_e;
    logic [WIDTH:0]     w_sum, w_dif;
    logic [SHW-1:0]     w_amt, w_rot;
    logic [WIDTH:0]     w_shift, w_sub;
    logic               w_ge;
    logic [WIDTH-1:0]   w_quo_nx, w_rem_nx, w_div_res;

    assign in_ready    = !rst && (r_state == S_IDLE || (r_state == S_HOLD && out_ready));
    assign out_valid   = (r_state == S_HOLD);
    assign w_accept    = in_valid && in_ready;
    assign w_div_start = w_accept && (opcode == OP_DIV || opcode == OP_REM) && (b != '0);
    assign w_div_last  = (r_state == S_BUSY) && (r_cnt == CW'(WIDTH - 1));

    assign result    = r_result;
    assign zero      = r_zero;
    assign carry_out = r_carry;
    assign overflow  = r_ovf;
    assign err       = r_err;
    assign dbg_state = r_state;

    // Shared adder/subtractor and shift amounts; rotates wrap modulo WIDTH.
    assign w_sum = {1'b0, a} + {1'b0, b};
    assign w_dif = {1'b0, a} - {1'b0, b};
    assign w_amt = b[SHW-1:0];
    assign w_rot = SHW'(32'(w_amt) % WIDTH);

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    assign w_shift   = {r_rem, r_quo[M]};
    assign w_sub     = w_shift - {1'b0, r_div};
    assign w_ge      = !w_sub[WIDTH];
    assign w_rem_nx  = w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_nx  = {r_quo[WIDTH-2:0], w_ge};
    assign w_div_res = r_is_rem ? w_rem_nx : w_quo_nx;

    // Single-cycle result and flags for the opcode presented this cycle.
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_e   = 1'b0;
        case (opcode)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (a[M] == b[M]) && (w_sum[M] != a[M]);
            end
            OP_SUB: begin
                w_res = w_dif[WIDTH-1:0];
                w_c   = w_dif[WIDTH];
                w_v   = (a[M] != b[M]) && (w_dif[M] != a[M]);
            end
`ifdef SEQ_ALU_MUL_EN
            OP_MUL:  w_res = a * b;
`else
            OP_MUL:  w_e = 1'b1;
`endif
            OP_DIV, OP_REM: w_e = (b == '0);
            OP_AND:  w_res = a & b;
            OP_OR:   w_res = a | b;
            OP_XOR:  w_res = a ^ b;
            OP_NAND: w_res = ~(a & b);
            OP_NOR:  w_res = ~(a | b);
            OP_XNOR: w_res = ~(a ^ b);
            OP_NOT:  w_res = ~a;
            OP_NEG:  w_res = '0 - a;
            OP_SLL:  w_res = a << w_amt;
            OP_SRL:  w_res = a >> w_amt;
            OP_SRA:  w_res = WIDTH'($signed(a) >>> w_amt);
            OP_SLT:  w_res = {WIDTH{$signed(a) < $signed(b)}};
            OP_SLTU: w_res = {WIDTH{a < b}};
            OP_INC:  {w_c, w_res} = {1'b0, a} + (WIDTH+1)'(1);
            OP_DEC:  {w_c, w_res} = {1'b0, a} - (WIDTH+1)'(1);
            OP_ROL:  w_res = (a << w_rot) | (a >> (WIDTH - 32'(w_rot)));
            OP_ROR:  w_res = (a >> w_rot) | (a << (WIDTH - 32'(w_rot)));
            OP_PSA:  w_res = a;
            OP_PSB:  w_res = b;
            default: w_e = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic; an accept out of HOLD behaves exactly like one out of IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_div_start ? S_BUSY : S_HOLD;
            S_BUSY: if (w_div_last) w_next = S_HOLD;
            S_HOLD: if (out_ready) w_next = w_accept ? (w_div_start ? S_BUSY : S_HOLD) : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: capture single-cycle results, load and step the divider.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_is_rem <= 1'b0;
        end else if (w_accept) begin
            if (w_div_start) begin
                r_quo    <= a;
                r_rem    <= '0;
                r_div    <= b;
                r_cnt    <= '0;
                r_is_rem <= (opcode == OP_REM);
            end else begin
                r_result <= w_res;
                r_zero   <= (w_res == '0);
                r_carry  <= w_c;
                r_ovf    <= w_v;
                r_err    <= w_e;
            end
        end else if (r_state == S_BUSY) begin
            r_quo <= w_quo_nx;
            r_rem <= w_rem_nx;
            r_cnt <= r_cnt + CW'(1);
            if (w_div_last) begin
                r_result <= w_div_res;
                r_zero   <= (w_div_res == '0);
                r_carry  <= 1'b0;
                r_ovf    <= 1'b0;
                r_err    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: self-checking bench for seq_alu (WIDTH=16). A reference model
// computes each accepted request's result/flags/latency from plain arithmetic;
// a per-cycle monitor compares out_valid, in_ready and the outputs against it.
module tb_seq_alu;

    localparam int W = 16;

    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_MUL = 5'd2,  OP_DIV = 5'd3;
    localparam logic [4:0] OP_REM = 5'd4,  OP_SRA = 5'd15, OP_ROL = 5'd20, OP_BAD = 5'd24;

    logic          clk, rst, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  a, b, result;
    logic [4:0]    opcode;
    logic          zero, carry_out, overflow, err;
    logic [1:0]    dbg_state;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            k        = 0;
    bit            after_rst = 0;
    bit            rand_ordy = 0;
    bit            ordy_force = 1;
    logic [W+3:0]  exp_q[$];
    int            due_q[$];

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .carry_out(carry_out), .overflow(overflow),
        .err(err), .dbg_state(dbg_state)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // global watchdog
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, required finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: {result, zero, carry, overflow, err} from the opcode rules.
    function automatic logic [W+3:0] model(input logic [4:0] op, input logic [W-1:0] ai, input logic [W-1:0] bi);
        longint ua, ub, sa, sb, r, sv;
        int n;
        bit c, v, e;
        ua = longint'(ai);
        ub = longint'(bi);
        sa = (ua >= 32768) ? ua - 65536 : ua;
        sb = (ub >= 32768) ? ub - 65536 : ub;
        n  = int'(ub % 16);
        r = 0; c = 0; v = 0; e = 0;
        case (op)
            5'd0:  begin r = ua + ub; c = (r > 65535); sv = sa + sb; v = (sv > 32767) || (sv < -32768); end
            5'd1:  begin r = ua - ub; c = (ua < ub);   sv = sa - sb; v = (sv > 32767) || (sv < -32768); end
`ifdef SEQ_ALU_MUL_EN
            5'd2:  r = ua * ub;
`else
            5'd2:  e = 1;
`endif
            5'd3:  if (ub == 0) e = 1; else r = ua / ub;
            5'd4:  if (ub == 0) e = 1; else r = ua % ub;
            5'd5:  r = ua & ub;
            5'd6:  r = ua | ub;
            5'd7:  r = ua ^ ub;
            5'd8:  r = ~(ua & ub);
            5'd9:  r = ~(ua | ub);
            5'd10: r = ~(ua ^ ub);
            5'd11: r = ~ua;
            5'd12: r = -ua;
            5'd13: r = ua << n;
            5'd14: r = ua >> n;
            5'd15: r = sa >>> n;
            5'd16: r = (sa < sb) ? 65535 : 0;
            5'd17: r = (ua < ub) ? 65535 : 0;
            5'd18: begin r = ua + 1; c = (ua == 65535); end
            5'd19: begin r = ua - 1; c = (ua == 0); end
            5'd20: r = (ua << n) | (ua >> (16 - n));
            5'd21: r = (ua >> n) | (ua << (16 - n));
            5'd22: r = ua;
            5'd23: r = ub;
            default: e = 1;
        endcase
        r = r & 65535;
        return {r[15:0], (r == 0), c, v, e};
    endfunction

    function automatic int latency(input logic [4:0] op, input logic [W-1:0] bi);
        return ((op == 5'd3 || op == 5'd4) && bi != 0) ? W + 1 : 1;
    endfunction

    // Per-cycle compare against the model; then advance the model for the coming edge.
    always @(negedge clk) begin
        bit ev, eir;
        k++;
        ev  = (exp_q.size() != 0) && (k >= due_q[0]);
        eir = !rst && ((exp_q.size() == 0) || (ev && out_ready));
        check("out_valid", 64'(out_valid), 64'(ev));
        check("in_ready", 64'(in_ready), 64'(eir));
        if (after_rst) begin
            check("reset_outputs", 64'({result, zero, carry_out, overflow, err}), 64'(0));
            after_rst = 0;
        end
        if (ev) check("result_flags", 64'({result, zero, carry_out, overflow, err}), 64'(exp_q[0]));
        if (rst) begin
            exp_q.delete();
            due_q.delete();
            after_rst = 1;
        end else begin
            if (ev && out_ready) begin
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
            end
            if (in_valid && eir) begin
                exp_q.push_back(model(opcode, a, b));
                due_q.push_back(k + latency(opcode, b));
            end
        end
    end

    // out_ready driver: random during the random phase, otherwise forced.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ordy ? 1'($urandom_range(0, 1)) : ordy_force;
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Present a request (called just after a rising edge); returns just after the accepting edge.
    task automatic send(input logic [4:0] op, input logic [W-1:0] ai, input logic [W-1:0] bi);
        bit ok = 0;
        opcode   = op;
        a        = ai;
        b        = bi;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("send_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait for the result and pin it and its latency to hand-computed values.
    task automatic wait_result(input string name, input int lat, input logic [W+3:0] exp);
        int cnt = 0;
        bit got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cnt++;
            if (out_valid) begin
                got = 1;
                break;
            end
        end
        check({name, "_latency"}, 64'(cnt), 64'(lat));
        if (got) check({name, "_value"}, 64'({result, zero, carry_out, overflow, err}), 64'(exp));
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            4: return 16'h0001;
            default: return W'($urandom_range(0, 65535));
        endcase
    endfunction

    initial begin
        logic [4:0] op;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; opcode = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // directed cases with hand-computed expectations {result, zero, carry, ovf, err}
        send(OP_ADD, 16'h7FFF, 16'h0001); wait_result("add_ovf",  1, {16'h8000, 4'b0010}); sync();
        send(OP_ADD, 16'hFFFF, 16'h0001); wait_result("add_carry", 1, {16'h0000, 4'b1100}); sync();
        send(OP_SUB, 16'h0000, 16'h0001); wait_result("sub_borrow", 1, {16'hFFFF, 4'b0100}); sync();
        send(OP_SUB, 16'h8000, 16'h0001); wait_result("sub_ovf",  1, {16'h7FFF, 4'b0010}); sync();
        send(OP_SRA, 16'h8000, 16'h0004); wait_result("sra",      1, {16'hF800, 4'b0000}); sync();
        send(OP_DIV, 16'd1000, 16'd7);    wait_result("div",  W + 1, {16'd142, 4'b0000}); sync();
        send(OP_REM, 16'd1000, 16'd7);    wait_result("rem",  W + 1, {16'd6,   4'b0000}); sync();
        send(OP_DIV, 16'd5, 16'd0);       wait_result("div0",     1, {16'd0,   4'b1001}); sync();
        send(OP_BAD, 16'd9, 16'd9);       wait_result("bad_op",   1, {16'd0,   4'b1001}); sync();
`ifdef SEQ_ALU_MUL_EN
        send(OP_MUL, 16'd3, 16'd4);       wait_result("mul",      1, {16'd12,  4'b0000}); sync();
`else
        send(OP_MUL, 16'd3, 16'd4);       wait_result("mul_off",  1, {16'd0,   4'b1001}); sync();
`endif

        // result held while the consumer stalls, then back-to-back accept
        ordy_force = 1'b0;
        sync();
        send(OP_ADD, 16'd1, 16'd2);
        wait_result("stall_add", 1, {16'd3, 4'b0000});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'(0));
            check("stall_result", 64'(result), 64'(3));
        end
        ordy_force = 1'b1;
        sync();
        send(OP_ROL, 16'h8001, 16'd4);
        wait_result("rol_after_stall", 1, {16'h0018, 4'b0000});
        sync();

        // reset in the middle of a division
        send(OP_DIV, 16'd1000, 16'd7);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_outputs", 64'({result, zero, carry_out, overflow, err}), 64'(0));
        repeat (30) @(negedge clk);
        sync();

        // randomized traffic with random consumer back-pressure
        rand_ordy = 1'b1;
        repeat (400) begin
            op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
            send(op, pick(), pick());
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) sync();
        end

        // drain
        rand_ordy = 1'b0;
        ordy_force = 1'b1;
        repeat (40) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
